// File: rtl/frame_parity_chk_pkg.sv
// Shared encodings for the serial frame receiver: parity modes and FSM states.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    PAR_EVEN  = 2'b00,
    PAR_ODD   = 2'b01,
    PAR_MARK  = 2'b10,
    PAR_SPACE = 2'b11
  } par_typ_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DATA   = 2'b01,
    PARITY = 2'b10,
    STOP   = 2'b11
  } state_e;

endpackage

// File: rtl/frame_parity_chk_if.sv
// Bit-stream input and frame-result bundle of frame_parity_chk.
interface frame_parity_chk_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
);
  logic                  frm_start;
  logic                  bit_valid;
  logic                  sampled_bit;
  logic                  PAR_EN;
  logic [1:0]            PAR_TYP;
  logic                  err_clr;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  frm_done;
  logic                  par_err;
  logic                  stp_err;
  logic                  busy;
  logic [CNT_WIDTH-1:0]  par_err_cnt;

  modport master (
    output frm_start, bit_valid, sampled_bit, PAR_EN, PAR_TYP, err_clr,
    input  data_out, frm_done, par_err, stp_err, busy, par_err_cnt
  );

  modport slave (
    input  frm_start, bit_valid, sampled_bit, PAR_EN, PAR_TYP, err_clr,
    output data_out, frm_done, par_err, stp_err, busy, par_err_cnt
  );
endinterface

// File: rtl/frame_parity_chk_par_calc.sv
// Expected parity bit from the running XOR accumulator and the selected parity mode.
module par_calc
  import uart_rx_pkg::*;
(
  input  logic     i_acc,
  input  par_typ_e i_par_typ,
  output logic     o_exp
);

  always_comb begin
    o_exp = 1'b0;
    case (i_par_typ)
      PAR_EVEN:  o_exp = i_acc;
      PAR_ODD:   o_exp = ~i_acc;
      PAR_MARK:  o_exp = 1'b1;
      PAR_SPACE: o_exp = 1'b0;
    endcase
  end

endmodule

// File: rtl/frame_parity_chk.sv
// Serial frame receiver with parity and stop-bit checking.
// Define PAR_ERR_CNT_EN to build the saturating parity-error counter.
module frame_parity_chk
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic              CLK,
  input  logic              RST,
  frame_parity_chk_if.slave bus
);

  localparam int             BCW      = $clog2(DATA_WIDTH + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

  state_e                r_state;
  state_e                w_state_next;
  logic [BCW-1:0]        r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_acc;
  logic                  r_par_en;
  par_typ_e              r_par_typ;
  logic                  r_par_mis;
  logic                  r_par_err;
  logic                  r_stp_err;
  logic                  r_frm_done;
  logic                  w_exp;
  logic                  w_busy;
  logic                  w_last_bit;

  assign w_last_bit = (r_bit_cnt == LAST_BIT);

  par_calc u_par_calc (
    .i_acc     (r_acc),
    .i_par_typ (r_par_typ),
    .o_exp     (w_exp)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  // frm_start restarts the frame from any state and outranks a coincident bit.
  always_comb begin
    w_state_next = r_state;
    if (bus.frm_start) begin
      w_state_next = DATA;
    end else if (bus.bit_valid) begin
      case (r_state)
        DATA:    if (w_last_bit) w_state_next = r_par_en ? PARITY : STOP;
        PARITY:  w_state_next = STOP;
        STOP:    w_state_next = IDLE;
        default: w_state_next = r_state;
      endcase
    end
  end

  always_comb begin
    w_busy = (r_state != IDLE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_bit_cnt  <= '0;
      r_data     <= '0;
      r_acc      <= 1'b0;
      r_par_en   <= 1'b0;
      r_par_typ  <= PAR_EVEN;
      r_par_mis  <= 1'b0;
      r_data_out <= '0;
      r_par_err  <= 1'b0;
      r_stp_err  <= 1'b0;
      r_frm_done <= 1'b0;
    end else begin
      r_frm_done <= 1'b0;
      if (bus.frm_start) begin
        r_bit_cnt <= '0;
        r_acc     <= 1'b0;
        r_par_mis <= 1'b0;
        r_par_err <= 1'b0;
        r_stp_err <= 1'b0;
        r_par_en  <= bus.PAR_EN;
        r_par_typ <= par_typ_e'(bus.PAR_TYP);
      end else if (bus.bit_valid) begin
        case (r_state)
          DATA: begin
            r_data    <= {bus.sampled_bit, r_data[DATA_WIDTH-1:1]};
            r_acc     <= r_acc ^ bus.sampled_bit;
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
          PARITY: r_par_mis <= (bus.sampled_bit != w_exp);
          // Results are published together so they are coherent in the frm_done cycle.
          STOP: begin
            r_stp_err  <= ~bus.sampled_bit;
            r_par_err  <= r_par_en & r_par_mis;
            r_data_out <= r_data;
            r_frm_done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef PAR_ERR_CNT_EN
  logic [CNT_WIDTH-1:0] r_par_err_cnt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_par_err_cnt <= '0;
    end else if (bus.err_clr) begin
      r_par_err_cnt <= '0;
    end else if (r_frm_done && r_par_err && (r_par_err_cnt != {CNT_WIDTH{1'b1}})) begin
      r_par_err_cnt <= r_par_err_cnt + 1'b1;
    end
  end

  assign bus.par_err_cnt = r_par_err_cnt;
`else
  logic w_unused_err_clr;
  assign w_unused_err_clr = bus.err_clr;
  assign bus.par_err_cnt  = '0;
`endif

  assign bus.data_out = r_data_out;
  assign bus.frm_done = r_frm_done;
  assign bus.par_err  = r_par_err;
  assign bus.stp_err  = r_stp_err;
  assign bus.busy     = w_busy;

endmodule

// File: tb/tb_frame_parity_chk.sv
// Directed bench for frame_parity_chk: 8-bit, 2-bit-counter and 5-bit instances share one stimulus.
module tb_frame_parity_chk;
  import uart_rx_pkg::*;

`ifdef PAR_ERR_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frm_start = 1'b0;
  logic       bit_valid = 1'b0;
  logic       sampled_bit = 1'b0;
  logic       par_en = 1'b0;
  logic [1:0] par_typ = 2'b00;
  logic       err_clr = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int done8 = 0;
  int done5 = 0;
  int cnt8_exp = 0;
  int cnt2_exp = 0;
  int cnt5_exp = 0;

  always #5 clk = ~clk;

  frame_parity_chk_if #(.DATA_WIDTH(8), .CNT_WIDTH(8)) if8 ();
  frame_parity_chk_if #(.DATA_WIDTH(8), .CNT_WIDTH(2)) ifc2 ();
  frame_parity_chk_if #(.DATA_WIDTH(5), .CNT_WIDTH(8)) if5 ();

  assign if8.frm_start   = frm_start;
  assign if8.bit_valid   = bit_valid;
  assign if8.sampled_bit = sampled_bit;
  assign if8.PAR_EN      = par_en;
  assign if8.PAR_TYP     = par_typ;
  assign if8.err_clr     = err_clr;
  assign ifc2.frm_start   = frm_start;
  assign ifc2.bit_valid   = bit_valid;
  assign ifc2.sampled_bit = sampled_bit;
  assign ifc2.PAR_EN      = par_en;
  assign ifc2.PAR_TYP     = par_typ;
  assign ifc2.err_clr     = err_clr;
  assign if5.frm_start   = frm_start;
  assign if5.bit_valid   = bit_valid;
  assign if5.sampled_bit = sampled_bit;
  assign if5.PAR_EN      = par_en;
  assign if5.PAR_TYP     = par_typ;
  assign if5.err_clr     = err_clr;

  frame_parity_chk #(.DATA_WIDTH(8), .CNT_WIDTH(8)) dut8  (.CLK(clk), .RST(rst_n), .bus(if8));
  frame_parity_chk #(.DATA_WIDTH(8), .CNT_WIDTH(2)) dutc2 (.CLK(clk), .RST(rst_n), .bus(ifc2));
  frame_parity_chk #(.DATA_WIDTH(5), .CNT_WIDTH(8)) dut5  (.CLK(clk), .RST(rst_n), .bus(if5));

  always @(posedge clk) begin
    if (if8.frm_done === 1'b1) done8 = done8 + 1;
    if (if5.frm_done === 1'b1) done5 = done5 + 1;
  end

  function automatic int inc_sat(input int c, input int maxv);
    return CNT_ON ? ((c < maxv) ? c + 1 : c) : 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sampled_bit = b;
    bit_valid   = 1'b1;
    tick();
    bit_valid   = 1'b0;
  endtask

  task automatic start_frame(input logic en, input logic [1:0] typ, input logic coinc);
    frm_start   = 1'b1;
    par_en      = en;
    par_typ     = typ;
    bit_valid   = coinc;
    sampled_bit = coinc;
    tick();
    frm_start   = 1'b0;
    bit_valid   = 1'b0;
  endtask

  // Returns one cycle after the stop-bit strobe, i.e. inside the frm_done cycle.
  task automatic send_frame(input logic [8:0] d, input int n, input logic en,
                            input logic [1:0] typ, input logic pb, input logic sb,
                            input logic coinc);
    start_frame(en, typ, coinc);
    for (int i = 0; i < n; i++) send_bit(d[i]);
    if (en) send_bit(pb);
    send_bit(sb);
    $display("frame dw%0d data=%h par_en=%b typ=%0d pbit=%b stop=%b -> data_out=%h par_err=%b stp_err=%b",
             n, d, en, typ, pb, sb, (n == 5) ? 8'(if5.data_out) : if8.data_out,
             (n == 5) ? if5.par_err : if8.par_err, (n == 5) ? if5.stp_err : if8.stp_err);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_vec++; if (if8.data_out !== 8'h00) begin n_err++; $display("FAIL reset_data_out got=%h exp=00", if8.data_out); end
    n_vec++; if (if8.frm_done !== 1'b0) begin n_err++; $display("FAIL reset_frm_done got=%b exp=0", if8.frm_done); end
    n_vec++; if (if8.par_err !== 1'b0) begin n_err++; $display("FAIL reset_par_err got=%b exp=0", if8.par_err); end
    n_vec++; if (if8.stp_err !== 1'b0) begin n_err++; $display("FAIL reset_stp_err got=%b exp=0", if8.stp_err); end
    n_vec++; if (if8.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", if8.busy); end
    n_vec++; if (if8.par_err_cnt !== 8'h00) begin n_err++; $display("FAIL reset_cnt got=%h exp=00", if8.par_err_cnt); end
    rst_n = 1'b1;
    tick();
    n_vec++; if (if8.busy !== 1'b0) begin n_err++; $display("FAIL post_reset_busy got=%b exp=0", if8.busy); end
  endtask

  task automatic test_even();
    int d0;
    d0 = done8;
    send_frame(9'h0A5, 8, 1'b1, PAR_EVEN, 1'b0, 1'b1, 1'b0);
    n_vec++; if (if8.frm_done !== 1'b1) begin n_err++; $display("FAIL even_frm_done got=%b exp=1", if8.frm_done); end
    n_vec++; if (if8.data_out !== 8'hA5) begin n_err++; $display("FAIL even_data got=%h exp=a5", if8.data_out); end
    n_vec++; if (if8.par_err !== 1'b0) begin n_err++; $display("FAIL even_par_err got=%b exp=0", if8.par_err); end
    n_vec++; if (if8.stp_err !== 1'b0) begin n_err++; $display("FAIL even_stp_err got=%b exp=0", if8.stp_err); end
    n_vec++; if (if8.busy !== 1'b0) begin n_err++; $display("FAIL even_busy got=%b exp=0", if8.busy); end
    tick();
    n_vec++; if (if8.frm_done !== 1'b0) begin n_err++; $display("FAIL even_done_width got=%b exp=0", if8.frm_done); end
    n_vec++; if (done8 !== d0 + 1) begin n_err++; $display("FAIL even_done_count got=%0d exp=%0d", done8 - d0, 1); end
  endtask

  task automatic test_odd();
    send_frame(9'h0A5, 8, 1'b1, PAR_ODD, 1'b0, 1'b1, 1'b0);
    n_vec++; if (if8.par_err !== 1'b1) begin n_err++; $display("FAIL odd_par_err got=%b exp=1", if8.par_err); end
    n_vec++; if (if8.data_out !== 8'hA5) begin n_err++; $display("FAIL odd_data got=%h exp=a5", if8.data_out); end
    tick();
    cnt8_exp = inc_sat(cnt8_exp, 255);
    cnt2_exp = inc_sat(cnt2_exp, 3);
    n_vec++; if (if8.par_err_cnt !== 8'(cnt8_exp)) begin n_err++; $display("FAIL odd_cnt got=%0d exp=%0d", if8.par_err_cnt, cnt8_exp); end
    n_vec++; if (if8.par_err !== 1'b1) begin n_err++; $display("FAIL odd_par_err_hold got=%b exp=1", if8.par_err); end
  endtask

  task automatic test_mark_space();
    send_frame(9'h0A5, 8, 1'b1, PAR_MARK, 1'b0, 1'b1, 1'b0);
    n_vec++; if (if8.par_err !== 1'b1) begin n_err++; $display("FAIL mark_par_err got=%b exp=1", if8.par_err); end
    tick();
    cnt8_exp = inc_sat(cnt8_exp, 255);
    cnt2_exp = inc_sat(cnt2_exp, 3);
    send_frame(9'h0A5, 8, 1'b1, PAR_SPACE, 1'b1, 1'b1, 1'b0);
    n_vec++; if (if8.par_err !== 1'b1) begin n_err++; $display("FAIL space_par_err got=%b exp=1", if8.par_err); end
    tick();
    cnt8_exp = inc_sat(cnt8_exp, 255);
    cnt2_exp = inc_sat(cnt2_exp, 3);
    send_frame(9'h03C, 8, 1'b0, PAR_ODD, 1'b0, 1'b0, 1'b0);
    n_vec++; if (if8.data_out !== 8'h3C) begin n_err++; $display("FAIL nopar_data got=%h exp=3c", if8.data_out); end
    n_vec++; if (if8.par_err !== 1'b0) begin n_err++; $display("FAIL nopar_par_err got=%b exp=0", if8.par_err); end
    n_vec++; if (if8.stp_err !== 1'b1) begin n_err++; $display("FAIL nopar_stp_err got=%b exp=1", if8.stp_err); end
    tick();
    n_vec++; if (if8.par_err_cnt !== 8'(cnt8_exp)) begin n_err++; $display("FAIL ms_cnt got=%0d exp=%0d", if8.par_err_cnt, cnt8_exp); end
    n_vec++; if (ifc2.par_err_cnt !== 2'(cnt2_exp)) begin n_err++; $display("FAIL ms_cnt2 got=%0d exp=%0d", ifc2.par_err_cnt, cnt2_exp); end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 2; i++) begin
      send_frame(9'h000, 8, 1'b1, PAR_ODD, 1'b0, 1'b1, 1'b0);
      tick();
      cnt8_exp = inc_sat(cnt8_exp, 255);
      cnt2_exp = inc_sat(cnt2_exp, 3);
    end
    n_vec++; if (if8.par_err_cnt !== 8'(cnt8_exp)) begin n_err++; $display("FAIL sat_cnt8 got=%0d exp=%0d", if8.par_err_cnt, cnt8_exp); end
    n_vec++; if (ifc2.par_err_cnt !== 2'(cnt2_exp)) begin n_err++; $display("FAIL sat_cnt2 got=%0d exp=%0d", ifc2.par_err_cnt, cnt2_exp); end
  endtask

  task automatic test_err_clr();
    send_frame(9'h0A5, 8, 1'b1, PAR_MARK, 1'b0, 1'b1, 1'b0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    cnt8_exp = 0;
    cnt2_exp = 0;
    n_vec++; if (if8.par_err_cnt !== 8'(cnt8_exp)) begin n_err++; $display("FAIL clr_cnt8 got=%0d exp=%0d", if8.par_err_cnt, cnt8_exp); end
    n_vec++; if (ifc2.par_err_cnt !== 2'(cnt2_exp)) begin n_err++; $display("FAIL clr_cnt2 got=%0d exp=%0d", ifc2.par_err_cnt, cnt2_exp); end
    send_frame(9'h0A5, 8, 1'b1, PAR_MARK, 1'b0, 1'b1, 1'b0);
    tick();
    cnt8_exp = inc_sat(cnt8_exp, 255);
    n_vec++; if (if8.par_err_cnt !== 8'(cnt8_exp)) begin n_err++; $display("FAIL clr_recount got=%0d exp=%0d", if8.par_err_cnt, cnt8_exp); end
  endtask

  task automatic test_idle_abort();
    int d0;
    d0 = done8;
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    n_vec++; if (if8.busy !== 1'b0) begin n_err++; $display("FAIL idle_ignore_busy got=%b exp=0", if8.busy); end
    start_frame(1'b1, PAR_EVEN, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    n_vec++; if (if8.busy !== 1'b1) begin n_err++; $display("FAIL abort_busy got=%b exp=1", if8.busy); end
    send_frame(9'h05A, 8, 1'b1, PAR_EVEN, 1'b0, 1'b1, 1'b1);
    n_vec++; if (if8.data_out !== 8'h5A) begin n_err++; $display("FAIL abort_data got=%h exp=5a", if8.data_out); end
    n_vec++; if (if8.par_err !== 1'b0) begin n_err++; $display("FAIL abort_par_err got=%b exp=0", if8.par_err); end
    tick();
    n_vec++; if (done8 !== d0 + 1) begin n_err++; $display("FAIL abort_done_count got=%0d exp=%0d", done8 - d0, 1); end
  endtask

  task automatic test_back_to_back();
    int d0;
    d0 = done8;
    send_frame(9'h0A5, 8, 1'b1, PAR_ODD, 1'b0, 1'b1, 1'b0);
    n_vec++; if (if8.par_err !== 1'b1) begin n_err++; $display("FAIL b2b_first_par_err got=%b exp=1", if8.par_err); end
    cnt8_exp = inc_sat(cnt8_exp, 255);
    send_frame(9'h081, 8, 1'b1, PAR_EVEN, 1'b0, 1'b1, 1'b0);
    n_vec++; if (if8.data_out !== 8'h81) begin n_err++; $display("FAIL b2b_data got=%h exp=81", if8.data_out); end
    n_vec++; if (if8.par_err !== 1'b0) begin n_err++; $display("FAIL b2b_second_par_err got=%b exp=0", if8.par_err); end
    tick();
    n_vec++; if (done8 !== d0 + 2) begin n_err++; $display("FAIL b2b_done_count got=%0d exp=%0d", done8 - d0, 2); end
    n_vec++; if (if8.par_err_cnt !== 8'(cnt8_exp)) begin n_err++; $display("FAIL b2b_cnt got=%0d exp=%0d", if8.par_err_cnt, cnt8_exp); end
  endtask

  task automatic test_reset_mid();
    int d0;
    start_frame(1'b1, PAR_EVEN, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(1'b1);
    n_vec++; if (if8.busy !== 1'b1) begin n_err++; $display("FAIL rmid_busy_before got=%b exp=1", if8.busy); end
    d0 = done8;
    #1 rst_n = 1'b0;
    #1;
    cnt8_exp = 0;
    cnt2_exp = 0;
    cnt5_exp = 0;
    n_vec++; if (if8.data_out !== 8'h00) begin n_err++; $display("FAIL rmid_data got=%h exp=00", if8.data_out); end
    n_vec++; if (if8.busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy got=%b exp=0", if8.busy); end
    n_vec++; if (if8.par_err_cnt !== 8'(cnt8_exp)) begin n_err++; $display("FAIL rmid_cnt got=%0d exp=0", if8.par_err_cnt); end
    n_vec++; if (if8.frm_done !== 1'b0) begin n_err++; $display("FAIL rmid_frm_done got=%b exp=0", if8.frm_done); end
    send_bit(1'b1);
    send_bit(1'b1);
    rst_n = 1'b1;
    repeat (2) tick();
    n_vec++; if (done8 !== d0) begin n_err++; $display("FAIL rmid_done_count got=%0d exp=0", done8 - d0); end
    n_vec++; if (if8.busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy_after got=%b exp=0", if8.busy); end
  endtask

  task automatic test_dw5();
    int d0;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    cnt5_exp = 0;
    d0 = done5;
    send_frame(9'h016, 5, 1'b1, PAR_EVEN, 1'b1, 1'b1, 1'b0);
    n_vec++; if (if5.frm_done !== 1'b1) begin n_err++; $display("FAIL dw5_frm_done got=%b exp=1", if5.frm_done); end
    n_vec++; if (if5.data_out !== 5'h16) begin n_err++; $display("FAIL dw5_data got=%h exp=16", if5.data_out); end
    n_vec++; if (if5.par_err !== 1'b0) begin n_err++; $display("FAIL dw5_par_err got=%b exp=0", if5.par_err); end
    tick();
    send_frame(9'h016, 5, 1'b1, PAR_EVEN, 1'b0, 1'b1, 1'b0);
    n_vec++; if (if5.par_err !== 1'b1) begin n_err++; $display("FAIL dw5_bad_par_err got=%b exp=1", if5.par_err); end
    tick();
    cnt5_exp = inc_sat(cnt5_exp, 255);
    n_vec++; if (if5.par_err_cnt !== 8'(cnt5_exp)) begin n_err++; $display("FAIL dw5_cnt got=%0d exp=%0d", if5.par_err_cnt, cnt5_exp); end
    n_vec++; if (done5 !== d0 + 2) begin n_err++; $display("FAIL dw5_done_count got=%0d exp=%0d", done5 - d0, 2); end
  endtask

  initial begin
    test_reset();
    test_even();
    test_odd();
    test_mark_space();
    test_saturate();
    test_err_clr();
    test_idle_abort();
    test_back_to_back();
    test_reset_mid();
    test_dw5();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
